// File: rtl/spi_slave_core_pkg.sv
// spi_pkg: shared state encoding, SPI mode constants and counter sizing for spi_slave_core
package spi_pkg;
   typedef enum logic [1:0] {RESYNC, IDLE, ACTIVE} state_e;
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;
   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction
endpackage

// File: rtl/spi_slave_core_if.sv
// spi_slave_core_if: SPI pins plus rx/tx valid-ready word ports of spi_slave_core
interface spi_slave_core_if #(parameter int WIDTH = 32);
   logic sclk, ss_n, mosi;
   logic [WIDTH-1:0] rx_data, tx_data;
   logic rx_valid, rx_ready, tx_valid, tx_ready, overrun;
   modport slave (
      input  sclk, ss_n, mosi, rx_ready, tx_data, tx_valid,
      output rx_data, rx_valid, tx_ready, overrun
   );
   modport master (
      output sclk, ss_n, mosi, rx_ready, tx_data, tx_valid,
      input  rx_data, rx_valid, tx_ready, overrun
   );
endinterface

// File: rtl/spi_slave_core_sync.sv
// spi_sync: STAGES-deep synchroniser with a toggle detector against one further delayed copy
module spi_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic tgl_o
);
   logic [STAGES:0] sr_q;
   always_ff @(posedge clk_i) begin
      sr_q <= rst_i ? '0 : {sr_q[STAGES-1:0], d_i};
   end
   assign q_o = sr_q[STAGES-1];
   assign tgl_o = sr_q[STAGES-1] ^ sr_q[STAGES];
endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI slave, any CPOL/CPHA and width; SPI_SLAVE_OVERRUN_EN drops words on rx overrun
module spi_slave_core
   import spi_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter bit CPOL = 1'b0,
   parameter bit CPHA = 1'b0,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic miso_o,
   spi_slave_core_if.slave bus
);
   localparam int CW = cnt_w(WIDTH);
   state_e state_q;
   logic [CW-1:0] bit_cnt_q;
   logic [WIDTH-2:0] rx_sr_q;
   logic [WIDTH-1:0] rx_data_q, tx_buf_q, tx_sr_q, rx_word_d;
   logic rx_valid_q, tx_ready_q, overrun_q;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic sclk_s, sclk_e, ss_s, ss_e, lead, act, sample, shift, done, load, rx_ack, ovr, tx_wr;

   spi_sync #(.STAGES(SYNC_STAGES)) u_sclk (
      .clk_i(clk_i), .rst_i(rst_i), .d_i(bus.sclk), .q_o(sclk_s), .tgl_o(sclk_e)
   );
   spi_sync #(.STAGES(SYNC_STAGES)) u_ss (
      .clk_i(clk_i), .rst_i(rst_i), .d_i(bus.ss_n), .q_o(ss_s), .tgl_o(ss_e)
   );

   assign lead = sclk_e & (sclk_s ^ CPOL);
   // an SS rise in the same cycle as an SCLK edge ends the frame first
   assign act = state_q == ACTIVE && !(ss_e && ss_s);
   assign sample = act & (CPHA ? sclk_e & ~lead : lead);
   assign shift = act & (CPHA ? lead : sclk_e & ~lead);
   assign done = sample && bit_cnt_q == CW'(WIDTH - 1);
   assign load = (shift && bit_cnt_q == '0) || (!CPHA && state_q == IDLE && ss_e && !ss_s);
   assign rx_word_d = {rx_sr_q, mosi_q[SYNC_STAGES-1]};
   assign rx_ack = rx_valid_q & bus.rx_ready;
   assign tx_wr = bus.tx_valid & tx_ready_q;
`ifdef SPI_SLAVE_OVERRUN_EN
   assign ovr = done & rx_valid_q & ~bus.rx_ready;
`else
   assign ovr = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RESYNC;
         bit_cnt_q <= '0;
         rx_sr_q <= '0;
         rx_data_q <= '0;
         rx_valid_q <= 1'b0;
         overrun_q <= 1'b0;
         tx_buf_q <= '0;
         tx_ready_q <= 1'b1;
         tx_sr_q <= '0;
         mosi_q <= '0;
      end else begin
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
         state_q <= state_q == RESYNC ? (ss_s ? IDLE : RESYNC) :
                    state_q == IDLE ? (ss_e && !ss_s ? ACTIVE : IDLE) :
                    (ss_e && ss_s ? IDLE : ACTIVE);
         bit_cnt_q <= (!act || done) ? '0 : sample ? bit_cnt_q + 1'b1 : bit_cnt_q;
         if (sample) rx_sr_q <= rx_word_d[WIDTH-2:0];
         if (done && !ovr) rx_data_q <= rx_word_d;
         rx_valid_q <= done | (rx_valid_q & ~rx_ack);
         overrun_q <= ovr | (overrun_q & ~rx_ack);
         if (tx_wr) tx_buf_q <= bus.tx_data;
         tx_ready_q <= !tx_wr && (load || tx_ready_q);
         if (load) tx_sr_q <= tx_ready_q ? '0 : tx_buf_q;
         else if (shift) tx_sr_q <= tx_sr_q << 1;
      end
   end

   assign miso_o = bus.ss_n ? 1'bz : tx_sr_q[WIDTH-1];
   assign bus.rx_data = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.tx_ready = tx_ready_q;
   assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: table-driven SPI slave checks across widths/modes plus burst, abort, overrun and reset sequences
module tb_spi_slave_core;
   import spi_pkg::*;
   localparam int N = 5;
   localparam int H = 4;
   typedef struct {
      int idx;
      int w;
      logic [31:0] mo, tx, rx, mi;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] sclk = 5'b11000;
   logic [N-1:0] ss_n = '1;
   logic [N-1:0] mosi = '0;
   logic [N-1:0] rx_ready = '1;
   logic [N-1:0] tx_valid = '0;
   logic [N-1:0][31:0] tx_data = '0;
   logic [N-1:0][31:0] rx_data;
   logic [N-1:0] rx_valid, tx_ready, overrun;
   wire [N-1:0] miso;
   logic [31:0] got [N][64];
   int ngot [N] = '{default: 0};
   int nchk = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   function automatic logic [1:0] mode_of(input int i);
      return i <= 1 ? SPI_MODE0 : i == 2 ? SPI_MODE1 : i == 3 ? SPI_MODE2 : SPI_MODE3;
   endfunction

   for (genvar g = 0; g < N; g++) begin : gen_dut
      localparam int W = g == 0 ? 32 : 8;
      localparam logic [1:0] MD = mode_of(g);
      spi_slave_core_if #(.WIDTH(W)) bus ();
      assign bus.sclk = sclk[g];
      assign bus.ss_n = ss_n[g];
      assign bus.mosi = mosi[g];
      assign bus.rx_ready = rx_ready[g];
      assign bus.tx_valid = tx_valid[g];
      assign bus.tx_data = tx_data[g][W-1:0];
      assign rx_data[g] = 32'(bus.rx_data);
      assign rx_valid[g] = bus.rx_valid;
      assign tx_ready[g] = bus.tx_ready;
      assign overrun[g] = bus.overrun;
      spi_slave_core #(.WIDTH(W), .CPOL(MD[1]), .CPHA(MD[0]), .SYNC_STAGES(2)) dut (
         .clk_i(clk), .rst_i(rst), .miso_o(miso[g]), .bus(bus)
      );
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rx_valid[i] && rx_ready[i] && ngot[i] < 64) begin
            got[i][ngot[i]] <= rx_data[i];
            ngot[i] <= ngot[i] + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer(input int i, input int w, input logic [31:0] mo, output logic [31:0] mi);
      logic [1:0] md;
      md = mode_of(i);
      mi = '0;
      for (int k = w - 1; k >= 0; k--) begin
         if (!md[0]) mosi[i] = mo[k];
         cyc(H);
         if (!md[0]) mi = {mi[30:0], miso[i]};
         sclk[i] = ~md[1];
         if (md[0]) mosi[i] = mo[k];
         cyc(H);
         if (md[0]) mi = {mi[30:0], miso[i]};
         sclk[i] = md[1];
      end
      cyc(H);
   endtask

   task automatic push_tx(input int i, input logic [31:0] d);
      int n;
      n = 0;
      tx_data[i] = d;
      tx_valid[i] = 1'b1;
      while (!tx_ready[i] && n < 2000) begin
         cyc(1);
         n++;
      end
      chk($sformatf("tx_wait%0d", i), 32'(n < 2000), 32'd1);
      cyc(1);
      tx_valid[i] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs [7];
      logic [31:0] mi [3];
      logic [31:0] dm;
      int i, b;
      vecs[0] = '{0, 32, 32'hA5A5_0F0F, 32'h1234_5678, 32'hA5A5_0F0F, 32'h1234_5678};
      vecs[1] = '{1, 8, 32'h3C, 32'hC3, 32'h3C, 32'hC3};
      vecs[2] = '{2, 8, 32'h3C, 32'hC3, 32'h3C, 32'hC3};
      vecs[3] = '{3, 8, 32'h3C, 32'hC3, 32'h3C, 32'hC3};
      vecs[4] = '{4, 8, 32'h3C, 32'hC3, 32'h3C, 32'hC3};
      vecs[5] = '{1, 8, 32'h81, 32'h7E, 32'h81, 32'h7E};
      vecs[6] = '{3, 8, 32'h96, 32'h69, 32'h96, 32'h69};
      cyc(4);
      rst = 1'b0;
      cyc(10);
      chk("rst_rx_valid", 32'(rx_valid), 32'h0);
      chk("rst_tx_ready", 32'(tx_ready), 32'h1F);
      chk("rst_overrun", 32'(overrun), 32'h0);
      chk("rst_rx_data", rx_data[0], 32'h0);

      for (int v = 0; v < 7; v++) begin
         i = vecs[v].idx;
         push_tx(i, vecs[v].tx);
         b = ngot[i];
         ss_n[i] = 1'b0;
         cyc(8);
         xfer(i, vecs[v].w, vecs[v].mo, mi[0]);
         cyc(8);
         ss_n[i] = 1'b1;
         cyc(8);
         chk($sformatf("vec%0d_count", v), 32'(ngot[i] - b), 32'd1);
         chk($sformatf("vec%0d_rx", v), got[i][b], vecs[v].rx);
         chk($sformatf("vec%0d_miso", v), mi[0], vecs[v].mi);
         chk($sformatf("vec%0d_tx_ready", v), 32'(tx_ready[i]), 32'd1);
      end

      push_tx(1, 32'hAA);
      b = ngot[1];
      ss_n[1] = 1'b0;
      cyc(8);
      push_tx(1, 32'hBB);
      xfer(1, 8, 32'h11, mi[0]);
      xfer(1, 8, 32'h22, mi[1]);
      xfer(1, 8, 32'h33, mi[2]);
      cyc(8);
      ss_n[1] = 1'b1;
      cyc(8);
      chk("burst_count", 32'(ngot[1] - b), 32'd3);
      chk("burst_rx0", got[1][b], 32'h11);
      chk("burst_rx1", got[1][b+1], 32'h22);
      chk("burst_rx2", got[1][b+2], 32'h33);
      chk("burst_miso0", mi[0], 32'hAA);
      chk("burst_miso1", mi[1], 32'hBB);
      chk("burst_miso2", mi[2], 32'h00);

      b = ngot[1];
      ss_n[1] = 1'b0;
      cyc(8);
      xfer(1, 5, 32'h1B, dm);
      ss_n[1] = 1'b1;
      cyc(8);
      ss_n[1] = 1'b0;
      cyc(8);
      xfer(1, 8, 32'h7E, dm);
      cyc(8);
      ss_n[1] = 1'b1;
      cyc(8);
      chk("abort_count", 32'(ngot[1] - b), 32'd1);
      chk("abort_rx", got[1][b], 32'h7E);

      rx_ready[1] = 1'b0;
      b = ngot[1];
      ss_n[1] = 1'b0;
      cyc(8);
      xfer(1, 8, 32'h01, dm);
      xfer(1, 8, 32'h02, dm);
      cyc(8);
      ss_n[1] = 1'b1;
      cyc(8);
      chk("ovr_rx_valid", 32'(rx_valid[1]), 32'd1);
`ifdef SPI_SLAVE_OVERRUN_EN
      chk("ovr_rx_data", rx_data[1], 32'h01);
      chk("ovr_flag", 32'(overrun[1]), 32'd1);
`else
      chk("ovr_rx_data", rx_data[1], 32'h02);
      chk("ovr_flag", 32'(overrun[1]), 32'd0);
`endif
      rx_ready[1] = 1'b1;
      cyc(2);
      chk("ovr_drain_valid", 32'(rx_valid[1]), 32'd0);
      chk("ovr_drain_flag", 32'(overrun[1]), 32'd0);
      chk("ovr_drain_count", 32'(ngot[1] - b), 32'd1);

      b = ngot[1];
      ss_n[1] = 1'b0;
      cyc(8);
      xfer(1, 3, 32'h7, dm);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(4);
      chk("rstmid_miso", 32'(miso[1]), 32'd0);
      chk("rstmid_tx_ready", 32'(tx_ready[1]), 32'd1);
      xfer(1, 5, 32'h1F, dm);
      xfer(1, 8, 32'hA5, dm);
      cyc(8);
      chk("rstmid_none", 32'(ngot[1] - b), 32'd0);
      chk("rstmid_rx_valid", 32'(rx_valid[1]), 32'd0);
      ss_n[1] = 1'b1;
      cyc(8);
      ss_n[1] = 1'b0;
      cyc(8);
      xfer(1, 8, 32'h5A, dm);
      cyc(8);
      ss_n[1] = 1'b1;
      cyc(8);
      chk("rstmid_count", 32'(ngot[1] - b), 32'd1);
      chk("rstmid_rx", got[1][b], 32'h5A);
      chk("rstmid_rx_data", rx_data[1], 32'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Parametrised, system-clocked SPI slave replacing the SCLK-clocked receiver. It oversamples SCLK, SS and MOSI in the fabric clock domain and supports all four CPOL/CPHA modes and any word width. It provides full-duplex valid/ready word interfaces toward the control logic, with back-to-back multi-word bursts inside one SS assertion. It sits between the external SPI pins and the register/command decoder.

## Interface
- WIDTH, 32: bits per word, ≥ 2, MSB first.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- SYNC_STAGES, 2: synchroniser depth for SCLK/SS/MOSI, ≥ 2.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- SCLK, SS, MOSI  in  1 each  asynchronous SPI pins; SS active-low.
- MISO  out  1  serial data; 1'bz whenever raw SS is high.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready.
- tx_data  in  WIDTH  next word to transmit.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  tx buffer empty; transfer when tx_valid & tx_ready.
- overrun  out  1  sticky overrun flag; constant 0 when feature compiled out.

## Operation
- SCLK, SS and MOSI each pass through SYNC_STAGES flops. An edge is detected by comparing the synchronised SCLK with one further delayed copy.
- Leading edge: rising if CPOL=0, falling if CPOL=1. Sample edge is the leading edge if CPHA=0, otherwise the trailing edge. Shift edge is the other edge.
- States:
  - RESYNC: entered on RST. Bus is ignored. Go to IDLE when synchronised SS = 1, which prevents joining a frame mid-word.
  - IDLE: bit_cnt = 0. A synchronised SS 1→0 moves to ACTIVE. If CPHA=0, the tx shifter is loaded on that transition.
  - ACTIVE:
    - Sample edge: rx shifter ← {rx_sr[WIDTH-2:0], MOSI_sync}; bit_cnt += 1.
    - When bit_cnt = WIDTH-1 on a sample edge: rx_data ← completed word, rx_valid ← 1, bit_cnt wraps to 0.
    - Shift edge: if bit_cnt = 0, load the tx shifter; otherwise shift the tx shifter left by one.
    - Synchronised SS 0→1: go to IDLE. Partial rx word is discarded, bit_cnt ← 0, rx_valid unaffected.
- Tx shifter load: takes tx_data from the one-entry tx buffer and sets tx_ready ← 1. If the buffer is empty, it loads all zeros (underrun, no flag).
- Tx buffer: written when tx_valid & tx_ready, then tx_ready ← 0. A load and a new write in the same cycle are both honoured.
- MISO = tx_sr[WIDTH-1] while raw SS = 0.
- Rx handshake: rx_valid clears when rx_ready & rx_valid. If a word completes in the same cycle as a handshake, the new word wins and rx_valid stays 1.
- Rx overrun (word completes while rx_valid & ~rx_ready): behaviour is set by the macro (see Configuration).
- RST mid-frame: all state is reset and the block enters RESYNC. The rest of the frame is ignored.

## Timing
- Reset values: rx_data = 0, rx_valid = 0, tx_ready = 1, overrun = 0, tx_sr = 0. MISO is z while SS is high, else 0.
- Let k be the first CLK edge at which sync stage 1 captures an SCLK edge. The edge is acted on at CLK edge k+SYNC_STAGES.
- Consequences of that timing: rx_valid and MISO updates become visible after edge k+SYNC_STAGES. SS transitions incur the same latency.
- SCLK high and low phases must each be ≥ SYNC_STAGES+2 CLK periods. The minimum CLK/SCLK ratio is 2·(SYNC_STAGES+2), i.e. 8 at the default.
- For CPHA=0, SS falling must precede the first SCLK edge by ≥ SYNC_STAGES+2 CLK periods, so that MSB is on MISO before the first edge.
- tx_data for word n+1 must be written before the first shift edge of bit 0 of word n+1. Otherwise zeros are sent.

## Configuration
- SPI_SLAVE_OVERRUN_EN defined, on overrun:
  - the new word is dropped, rx_data is kept, and overrun ← 1;
  - overrun clears only on RST, or on the CLK edge where rx_valid & rx_ready while no new overrun occurs.
- Undefined, on overrun: the new word overwrites rx_data, rx_valid stays 1, and overrun is tied 0.

## Structure
- Package spi_pkg:
  - state enum {RESYNC, IDLE, ACTIVE};
  - mode constants SPI_MODE0..3 as {CPOL, CPHA} pairs;
  - a bit-count width function $clog2(WIDTH).
- Sub-module spi_sync: SYNC_STAGES-deep synchroniser plus a rise/fall edge detector. One instance each for SCLK and SS; MOSI uses only the synchroniser.

## Test plan
- Mode 0, WIDTH=32, CLK/SCLK=8: master sends 0xA5A5_0F0F while tx_data = 0x1234_5678 is preloaded. Required: rx_data = 0xA5A5_0F0F with one rx_valid pulse, and MISO returns 0x1234_5678.
- All four modes, WIDTH=8: send 0x3C with tx 0xC3 → rx 0x3C and MISO 0xC3 in every mode.
- Burst of 3 words (0x11, 0x22, 0x33) in one SS, tx buffer refilled with 0xAA, 0xBB only → rx gets all three words in order; MISO sends 0xAA, 0xBB, 0x00.
- SS deasserted after 5 of 8 bits, then a full 0x7E frame → exactly one rx_valid, rx_data = 0x7E.
- rx_ready held 0 across two words 0x01, 0x02:
  - with SPI_SLAVE_OVERRUN_EN: rx_data = 0x01 and overrun = 1;
  - without it: rx_data = 0x02 and overrun = 0.
- RST asserted mid-word with SS held low, then a fresh frame 0x5A → nothing is received until SS rises; the fresh frame gives rx_data = 0x5A.
